jtag_host: RTL and testbench

Clock-enabled JTAG host that drives TCK/TMS/TDI and samples TDO, acting as the initiator for a JTAG TAP such as `jtag_tap`. It accepts one command at a time: TAP reset, idle clocks, IR scan or DR scan of 1–32 bits. It walks the TAP state machine with fixed TMS sequences and returns the captured TDO bits. It is used by the on-chip debug/bring-up path and by the test bench to exercise chess-core TAP registers.

---
 rtl/jtag_host_pkg.sv | 39 +++
 rtl/jtag_host_tckgen.sv | 43 ++++
 rtl/jtag_host.sv | 161 ++++++++++++++++
 tb/tb_jtag_host.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_host_pkg.sv
// Shared types and constants for the JTAG host: command opcodes, FSM states,
// the latched command payload and the fixed PRE-phase TMS walks.
package jtag_host_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 5;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned PAT_W  = 6;

  typedef enum logic [1:0] {
    OP_TAP_RESET = 2'd0,
    OP_RUN_IDLE  = 2'd1,
    OP_SCAN_IR   = 2'd2,
    OP_SCAN_DR   = 2'd3
  } jtag_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRE   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_POST  = 2'd3
  } jtag_host_state_t;

  typedef struct packed {
    jtag_op_t          op;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] data;
  } jtag_cmd_t;

  // PRE TMS walks, bit 0 is driven first
  localparam logic [PAT_W-1:0] TMS_TAP_RESET = 6'b011111;  // 1,1,1,1,1,0
  localparam logic [PAT_W-1:0] TMS_PRE_IR    = 6'b000011;  // 1,1,0,0
  localparam logic [PAT_W-1:0] TMS_PRE_DR    = 6'b000001;  // 1,0,0

  localparam logic [CNT_W-1:0] LEN_TAP_RESET = 6'd6;
  localparam logic [CNT_W-1:0] LEN_PRE_IR    = 6'd4;
  localparam logic [CNT_W-1:0] LEN_PRE_DR    = 6'd3;

endpackage

// File: rtl/jtag_host_tckgen.sv
// TCK divider: while run is high, produces a TCK with HALF_PERIOD clk cycles
// low then HALF_PERIOD high, plus registered strobes marking the clk cycle
// whose ending edge raises (rise_en) or drops (fall_en) TCK.
// Ports: clk, rst_n, run (FSM busy), tck, rise_en, fall_en.
module jtag_host_tckgen #(
  parameter int unsigned HALF_PERIOD = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tck,
  output logic rise_en,
  output logic fall_en
);

  localparam int unsigned DIV_W = $clog2(2 * HALF_PERIOD);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  // Position within the TCK period; parked at 0 while idle
  always_comb begin
    div_d = '0;
    if (run && (div_q != DIV_W'(2 * HALF_PERIOD - 1))) begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      tck     <= 1'b0;
      rise_en <= 1'b0;
      fall_en <= 1'b0;
    end else begin
      div_q   <= div_d;
      tck     <= run && (div_d >= DIV_W'(HALF_PERIOD));
      rise_en <= run && (div_d == DIV_W'(HALF_PERIOD - 1));
      fall_en <= run && (div_d == DIV_W'(2 * HALF_PERIOD - 1));
    end
  end

endmodule

// File: rtl/jtag_host.sv
// JTAG host: accepts one command at a time (TAP reset, idle clocks, IR or DR
// scan of 1..32 bits), walks the target TAP with fixed TMS sequences and
// returns the TDO bits captured during the shift.
// Ports: clk, rst_n; command cmd_valid/cmd_ready/cmd_op/cmd_len/cmd_data;
// response rsp_valid/rsp_data; JTAG pins tck, tms, tdi (out), tdo (in).
module jtag_host
  import jtag_host_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo
);

  jtag_host_state_t  state;
  jtag_cmd_t         cmd_q;     // data field doubles as the TDI shift register
  logic [CNT_W-1:0]  cyc_cnt;   // TCK cycles left in the current phase, minus one
  logic [PAT_W-1:0]  tms_sr;
  logic [DATA_W-1:0] tdo_sr;
  logic              run;
  logic              rise_en;
  logic              fall_en;
  logic              is_scan;

  assign run     = (state != ST_IDLE);
  assign is_scan = (cmd_q.op == OP_SCAN_IR) || (cmd_q.op == OP_SCAN_DR);

  jtag_host_tckgen #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_tckgen (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run),
    .tck     (tck),
    .rise_en (rise_en),
    .fall_en (fall_en)
  );

  // Command FSM; every TMS/TDI change lands on a TCK falling edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cmd_q     <= '0;
      cyc_cnt   <= '0;
      tms_sr    <= '0;
      tdo_sr    <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_q.op   <= jtag_op_t'(cmd_op);
            cmd_q.len  <= cmd_len;
            cmd_q.data <= cmd_data;
            cmd_ready  <= 1'b0;
            tdo_sr     <= '0;
            tdi        <= 1'b0;
            state      <= ST_PRE;
            case (jtag_op_t'(cmd_op))
              OP_TAP_RESET: begin
                tms     <= TMS_TAP_RESET[0];
                tms_sr  <= TMS_TAP_RESET >> 1;
                cyc_cnt <= CNT_W'(LEN_TAP_RESET - CNT_W'(1));
              end
              OP_RUN_IDLE: begin
                tms     <= 1'b0;
                tms_sr  <= '0;
                cyc_cnt <= CNT_W'(cmd_len);
              end
              OP_SCAN_IR: begin
                tms     <= TMS_PRE_IR[0];
                tms_sr  <= TMS_PRE_IR >> 1;
                cyc_cnt <= CNT_W'(LEN_PRE_IR - CNT_W'(1));
              end
              default: begin
                tms     <= TMS_PRE_DR[0];
                tms_sr  <= TMS_PRE_DR >> 1;
                cyc_cnt <= CNT_W'(LEN_PRE_DR - CNT_W'(1));
              end
            endcase
          end
        end

        ST_PRE: begin
          if (fall_en) begin
            if (cyc_cnt != '0) begin
              tms     <= tms_sr[0];
              tms_sr  <= tms_sr >> 1;
              cyc_cnt <= cyc_cnt - CNT_W'(1);
            end else if (is_scan) begin
              // A 1-bit scan leaves Shift on its only cycle
              state      <= ST_SHIFT;
              cyc_cnt    <= CNT_W'(cmd_q.len);
              tms        <= (cmd_q.len == '0);
              tdi        <= cmd_q.data[0];
              cmd_q.data <= cmd_q.data >> 1;
            end else begin
              state     <= ST_IDLE;
              cmd_ready <= 1'b1;
              rsp_valid <= 1'b1;
              rsp_data  <= '0;
            end
          end
        end

        ST_SHIFT: begin
          if (rise_en) begin
            tdo_sr <= {tdo, tdo_sr[DATA_W-1:1]};
          end
          if (fall_en) begin
            if (cyc_cnt != '0) begin
              tms        <= (cyc_cnt == CNT_W'(1));
              tdi        <= cmd_q.data[0];
              cmd_q.data <= cmd_q.data >> 1;
              cyc_cnt    <= cyc_cnt - CNT_W'(1);
            end else begin
              state   <= ST_POST;
              tms     <= 1'b1;
              tdi     <= 1'b0;
              cyc_cnt <= CNT_W'(1);
            end
          end
        end

        ST_POST: begin
          if (fall_en) begin
            if (cyc_cnt != '0) begin
              tms     <= 1'b0;
              cyc_cnt <= cyc_cnt - CNT_W'(1);
            end else begin
              state     <= ST_IDLE;
              cmd_ready <= 1'b1;
              rsp_valid <= 1'b1;
              // Captured bits sit at the top of tdo_sr; shift by 32-L = ~len
              rsp_data  <= tdo_sr >> (~cmd_q.len);
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_host.sv
// Bench for jtag_host: a behavioural TAP target (IDCODE 0x1392001D, USER IR
// 0x41 with an 8-bit stub capturing 0x3C) plus a TCK-level monitor. Each
// command's TMS/TDI trace, latency and response are checked against
// sequences built from the TAP walk rules.
`timescale 1ns/1ps
module tb_jtag_host;

  localparam int unsigned H = 2;

  // TAP controller states
  localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5,
                 PADR = 6, EX2DR = 7, UPDR = 8, SELIR = 9, CAPIR = 10,
                 SHIR = 11, EX1IR = 12, PAIR = 13, EX2IR = 14, UPIR = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [4:0]  cmd_len = 5'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        cmd_ready, rsp_valid;
  logic [31:0] rsp_data;
  logic        tck, tms, tdi, tdo;

  always #5 clk = ~clk;

  jtag_host #(.HALF_PERIOD(H)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural target + TCK monitor ----------------
  bit obs_tms[$], obs_tdi[$], obs_tdo[$];
  logic        tck_q = 1'b0;
  int          tap_st = TLR;
  logic [7:0]  ir = 8'hFE;
  logic [7:0]  ir_sr = 8'h00;
  logic [31:0] dr_sr = 32'h0;
  int          dr_len = 1;
  logic [7:0]  stub_rx = 8'h00;
  bit          use_tap = 1'b1;
  logic        tap_tdo = 1'b0;
  logic        rnd_tdo = 1'b0;

  assign tdo = use_tap ? tap_tdo : rnd_tdo;

  function automatic int tap_next(input int s, input logic m);
    case (s)
      TLR:   return m ? TLR   : RTI;
      RTI:   return m ? SELDR : RTI;
      SELDR: return m ? SELIR : CAPDR;
      CAPDR: return m ? EX1DR : SHDR;
      SHDR:  return m ? EX1DR : SHDR;
      EX1DR: return m ? UPDR  : PADR;
      PADR:  return m ? EX2DR : PADR;
      EX2DR: return m ? UPDR  : SHDR;
      UPDR:  return m ? SELDR : RTI;
      SELIR: return m ? TLR   : CAPIR;
      CAPIR: return m ? EX1IR : SHIR;
      SHIR:  return m ? EX1IR : SHIR;
      EX1IR: return m ? UPIR  : PAIR;
      PAIR:  return m ? EX2IR : PAIR;
      EX2IR: return m ? UPIR  : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  always @(negedge clk) begin
    if (tck === 1'b1 && tck_q === 1'b0) begin
      obs_tms.push_back(tms);
      obs_tdi.push_back(tdi);
      obs_tdo.push_back(tdo);
      case (tap_st)
        TLR:   ir = 8'hFE;
        CAPDR: begin
          if (ir == 8'hFE)      begin dr_sr = 32'h1392001D; dr_len = 32; end
          else if (ir == 8'h41) begin dr_sr = 32'h0000003C; dr_len = 8;  end
          else                  begin dr_sr = 32'h0;        dr_len = 1;  end
        end
        SHDR:  dr_sr = (dr_sr >> 1) | (32'(tdi) << (dr_len - 1));
        UPDR:  if (ir == 8'h41) stub_rx = dr_sr[7:0];
        CAPIR: ir_sr = ir;
        SHIR:  ir_sr = {tdi, ir_sr[7:1]};
        UPIR:  ir = ir_sr;
        default: ;
      endcase
      tap_st = tap_next(tap_st, tms);
    end else if (tck === 1'b0 && tck_q === 1'b1) begin
      tap_tdo = (tap_st == SHDR) ? dr_sr[0] : (tap_st == SHIR) ? ir_sr[0] : 1'b0;
      rnd_tdo = 1'($urandom_range(0, 1));
    end
    tck_q = tck;
  end

  // ---------------- expected TCK-level walk ----------------
  bit exp_tms[$], exp_tdi[$];

  task automatic push_exp(input bit m, input bit d);
    exp_tms.push_back(m);
    exp_tdi.push_back(d);
  endtask

  task automatic build_exp(input int op, input int L, input logic [31:0] d, output int pre);
    exp_tms.delete();
    exp_tdi.delete();
    pre = 0;
    case (op)
      0: begin
        for (int i = 0; i < 6; i++) push_exp(i < 5, 1'b0);
        pre = 6;
      end
      1: begin
        for (int i = 0; i < L; i++) push_exp(1'b0, 1'b0);
        pre = L;
      end
      default: begin
        if (op == 2) begin push_exp(1, 0); push_exp(1, 0); push_exp(0, 0); push_exp(0, 0); pre = 4; end
        else         begin push_exp(1, 0); push_exp(0, 0); push_exp(0, 0); pre = 3; end
        for (int i = 0; i < L; i++) push_exp(i == L - 1, d[i]);
        push_exp(1'b1, 1'b0);
        push_exp(1'b0, 1'b0);
      end
    endcase
  endtask

  // ---------------- command driver / checker ----------------
  task automatic start_cmd(input int op, input int L, input logic [31:0] d,
                           output int acc, output int base);
    int t;
    t = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && t < 4000) begin @(negedge clk); t++; end
    chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_len   = (op == 0) ? 5'($urandom) : 5'(L - 1);
    cmd_data  = d;
    acc  = cyc;
    base = obs_tms.size();
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_len   = 5'($urandom);
    cmd_data  = $urandom;
  endtask

  task automatic finish_cmd(input string name, input int op, input int L, input logic [31:0] d,
                            input int acc, input int base, input bit known, input logic [31:0] kexp,
                            output int rsp_cyc, output int base_now);
    int t, busy_bad, pre, n, errs;
    logic [31:0] exp_rsp, got;
    t = 0;
    busy_bad = 0;
    while (rsp_valid !== 1'b1 && t < 4000) begin
      if (cmd_ready !== 1'b0) busy_bad++;
      @(negedge clk);
      t++;
    end
    rsp_cyc  = cyc;
    base_now = obs_tms.size();
    got = rsp_data;
    chk({name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({name, " busy_ready"}, 32'(busy_bad), 32'd0);
    chk({name, " ready_at_done"}, 32'(cmd_ready), 32'd1);
    build_exp(op, L, d, pre);
    n = exp_tms.size();
    chk({name, " latency"}, 32'(cyc - acc), 32'(1 + 2 * n * H));
    chk({name, " tck_count"}, 32'(base_now - base), 32'(n));
    errs = 0;
    exp_rsp = 32'h0;
    for (int i = 0; i < n; i++) begin
      if (base + i < obs_tms.size()) begin
        if (obs_tms[base + i] != exp_tms[i] || obs_tdi[base + i] != exp_tdi[i]) errs++;
      end else begin
        errs++;
      end
    end
    if (op >= 2) begin
      for (int i = 0; i < L; i++)
        if (base + pre + i < obs_tdo.size()) exp_rsp[i] = obs_tdo[base + pre + i];
    end
    chk({name, " tms_tdi_trace"}, 32'(errs), 32'd0);
    chk({name, " rsp_data"}, got, exp_rsp);
    if (known) chk({name, " rsp_const"}, got, kexp);
    @(negedge clk);
    chk({name, " rsp_pulse"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic run_cmd(input string name, input int op, input int L, input logic [31:0] d,
                         input bit known, input logic [31:0] kexp);
    int acc, base, rc, bn;
    start_cmd(op, L, d, acc, base);
    finish_cmd(name, op, L, d, acc, base, known, kexp, rc, bn);
  endtask

  typedef struct {
    string       name;
    int          op;
    int          L;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int acc, base, rc, bn, acc2, base2, t, rises, pulses;

    tbl[0] = '{"tap_reset",   0, 6,  32'h0,        32'h0};
    tbl[1] = '{"ir_idcode",   2, 8,  32'hFE,       32'hFE};
    tbl[2] = '{"dr_idcode",   3, 32, 32'h0,        32'h1392001D};
    tbl[3] = '{"ir_user",     2, 8,  32'h41,       32'hFE};
    tbl[4] = '{"dr_user",     3, 8,  32'hA5,       32'h3C};
    tbl[5] = '{"run_idle5",   1, 5,  32'h0,        32'h0};
    tbl[6] = '{"dr_user2",    3, 8,  32'h5A,       32'h3C};

    // Reset state and quiet TCK
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset tck", 32'(tck), 32'd0);
    chk("reset tms", 32'(tms), 32'd1);
    chk("reset tdi", 32'(tdi), 32'd0);
    chk("reset ready", 32'(cmd_ready), 32'd1);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_data", rsp_data, 32'd0);
    rises = obs_tms.size();
    repeat (100) @(negedge clk);
    chk("reset no_tck", 32'(obs_tms.size() - rises), 32'd0);

    // Directed table against the target model
    use_tap = 1'b1;
    for (int i = 0; i < 7; i++) begin
      run_cmd(tbl[i].name, tbl[i].op, tbl[i].L, tbl[i].d, 1'b1, tbl[i].exp);
      if (i == 0) chk("tap_in_rti", 32'(tap_st), 32'(RTI));
      if (i == 4) chk("stub_rx_a5", 32'(stub_rx), 32'hA5);
    end
    chk("stub_rx_5a", 32'(stub_rx), 32'h5A);

    // Boundary lengths and random commands with random TDO
    use_tap = 1'b0;
    run_cmd("dr_len1",  3, 1,  32'h1, 1'b0, 32'h0);
    run_cmd("ir_len1",  2, 1,  32'h0, 1'b0, 32'h0);
    run_cmd("idle_len1", 1, 1, 32'h0, 1'b0, 32'h0);
    run_cmd("dr_len32", 3, 32, $urandom, 1'b0, 32'h0);
    run_cmd("ir_len32", 2, 32, $urandom, 1'b0, 32'h0);
    run_cmd("idle_len32", 1, 32, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 30; i++) begin
      int op, L;
      logic [31:0] d;
      op = $urandom_range(0, 3);
      L  = $urandom_range(1, 32);
      d  = $urandom;
      run_cmd("random", op, L, d, 1'b0, 32'h0);
    end

    // cmd_valid held through a scan with different data: back-to-back accept
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_len = 5'd15; cmd_data = 32'h0000C3A5;
    acc  = cyc;
    base = obs_tms.size();
    @(negedge clk);
    cmd_len  = 5'd11;
    cmd_data = 32'h00000F0F;
    finish_cmd("busy_first", 3, 16, 32'h0000C3A5, acc, base, 1'b0, 32'h0, acc2, base2);
    cmd_valid = 1'b0;
    finish_cmd("busy_second", 3, 12, 32'h00000F0F, acc2, base2, 1'b0, 32'h0, rc, bn);

    // Abort mid-scan with rst_n
    use_tap = 1'b1;
    start_cmd(3, 32, 32'hDEADBEEF, acc, base);
    t = 0;
    while (obs_tms.size() - base < 11 && t < 4000) begin @(negedge clk); t++; end
    chk("abort reached_tck10", 32'(obs_tms.size() - base), 32'd11);
    #2 rst_n = 1'b0;
    #1;
    chk("abort outputs", {27'd0, tck, tms, tdi, cmd_ready, rsp_valid}, 32'b01010);
    chk("abort rsp_data", rsp_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rises  = obs_tms.size();
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) pulses++;
    end
    chk("abort no_rsp", 32'(pulses), 32'd0);
    chk("abort no_tck", 32'(obs_tms.size() - rises), 32'd0);
    run_cmd("recover_reset", 0, 6, 32'h0, 1'b1, 32'h0);
    chk("recover_tap_rti", 32'(tap_st), 32'(RTI));
    run_cmd("recover_ir", 2, 8, 32'hFE, 1'b0, 32'h0);
    run_cmd("recover_idcode", 3, 32, 32'h0, 1'b1, 32'h1392001D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
